// File: rtl/fmap_stream_source.sv
// rtl/fmap_stream_source.sv - 3-channel pixel stream source fed from a synchronous frame RAM
// Optional zero-data flush tail after the last pixel: define FMAP_SRC_FLUSH_TAIL_EN.

module fmap_stream_source #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 224,
   parameter int HEIGHT     = 224,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  pause,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata_0,
   input  logic [DATA_WIDTH-1:0] mem_rdata_1,
   input  logic [DATA_WIDTH-1:0] mem_rdata_2,
   output logic [DATA_WIDTH-1:0] data_out_0,
   output logic [DATA_WIDTH-1:0] data_out_1,
   output logic [DATA_WIDTH-1:0] data_out_2,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STREAM = 3'd1,
      S_DRAIN  = 3'd2,
`ifdef FMAP_SRC_FLUSH_TAIL_EN
      S_TAIL   = 3'd3,
`endif
      S_DONE   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    rd_vld_q, rd_vld_d;
   logic                    out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0]   data0_q, data0_d;
   logic [DATA_WIDTH-1:0]   data1_q, data1_d;
   logic [DATA_WIDTH-1:0]   data2_q, data2_d;
   logic                    issue;

`ifdef FMAP_SRC_FLUSH_TAIL_EN
   localparam int             TCW       = $clog2(WIDTH + 1);
   localparam logic [TCW-1:0] TAIL_LAST = TCW'(WIDTH);

   logic [TCW-1:0]          tail_cnt_q, tail_cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
`ifdef FMAP_SRC_FLUSH_TAIL_EN
      tail_cnt_d = tail_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_STREAM;
               cnt_d   = '0;
            end
         end
         S_STREAM: begin
            // Counter parks on the last index rather than wrapping past the frame.
            if (!pause) begin
               issue = 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            // No read left in the RAM stage: the final pixel is on valid_out this cycle.
            if (!rd_vld_q) begin
`ifdef FMAP_SRC_FLUSH_TAIL_EN
               state_d    = S_TAIL;
               tail_cnt_d = '0;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef FMAP_SRC_FLUSH_TAIL_EN
         S_TAIL: begin
            if (tail_cnt_q == TAIL_LAST) begin
               state_d = S_DONE;
            end else begin
               tail_cnt_d = tail_cnt_q + TCW'(1);
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_vld_d  = issue;
      out_vld_d = rd_vld_q;
      data0_d   = rd_vld_q ? mem_rdata_0 : '0;
      data1_d   = rd_vld_q ? mem_rdata_1 : '0;
      data2_d   = rd_vld_q ? mem_rdata_2 : '0;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rd_vld_q  <= 1'b0;
         out_vld_q <= 1'b0;
         data0_q   <= '0;
         data1_q   <= '0;
         data2_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_vld_q  <= rd_vld_d;
         out_vld_q <= out_vld_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         data2_q   <= data2_d;
      end
   end

`ifdef FMAP_SRC_FLUSH_TAIL_EN
   always_ff @(posedge clk) begin
      if (resetn) begin
         tail_cnt_q <= '0;
      end else begin
         tail_cnt_q <= tail_cnt_d;
      end
   end
`endif

   assign mem_rd_en  = issue;
   assign mem_addr   = cnt_q;
   assign data_out_0 = data0_q;
   assign data_out_1 = data1_q;
   assign data_out_2 = data2_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

   // Tail beats carry zero data: the data registers are already cleared once the pipeline drains.
`ifdef FMAP_SRC_FLUSH_TAIL_EN
   assign valid_out = out_vld_q | (state_q == S_TAIL);
`else
   assign valid_out = out_vld_q;
`endif

endmodule

// File: doc/fmap_stream_source.md
# fmap_stream_source

Synthesizable 3-channel pixel stream source: reads a stored image plane-by-address from an external synchronous RAM and drives the `valid`/3×32-bit data stream consumed by the block1 convolution front end. It is the on-chip transmitter counterpart of the stream collector at the block outputs. It replaces file-based stimulus when the pipeline runs on hardware. It optionally appends the trailing flush cycles the line-buffer convolution needs to emit its last row.

## Interface
- `DATA_WIDTH`, 32: width of each channel sample (IEEE-754 single).
- `WIDTH`, 224: image width in pixels; set from `IMG_WIDTH` in dimension.v.
- `HEIGHT`, 224: image height in pixels; set from `IMG_HEIGHT`.
- `ADDR_WIDTH`, 16: RAM address width; must satisfy 2^ADDR_WIDTH ≥ WIDTH*HEIGHT.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-high reset. The name is kept for codebase uniformity; the polarity is high.
- `start` in 1: begin one frame; sampled only in IDLE.
- `pause` in 1: while high, no new RAM read is issued.
- `mem_rd_en` out 1: RAM read strobe.
- `mem_addr` out ADDR_WIDTH: pixel index, row-major, 0 … WIDTH*HEIGHT-1.
- `mem_rdata_0/1/2` in DATA_WIDTH: channel 0/1/2 read data, valid exactly 1 cycle after a `mem_rd_en` cycle.
- `data_out_0/1/2` out DATA_WIDTH: channel samples to the downstream `data_in_0/1/2`.
- `valid_out` out 1: drives downstream `valid_in`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the frame, including any tail, is complete.

## Operation
- FSM states are IDLE, STREAM, DRAIN, TAIL, DONE.
- IDLE:
  - If `start`=1, go to STREAM and clear the pixel counter.
  - `start` is ignored in every other state.
- STREAM: each cycle with `pause`=0:
  - assert `mem_rd_en`, drive `mem_addr` = counter, increment the counter;
  - after issuing index WIDTH*HEIGHT-1, go to DRAIN.
- STREAM with `pause`=1: `mem_rd_en`=0, `mem_addr` holds, the counter holds.
- Read pipeline:
  - a 2-stage valid shift (RAM latency, then output register);
  - `data_out_*` register `mem_rdata_*` on the cycle after the read;
  - `valid_out` is the issue strobe delayed 2 cycles;
  - in-flight reads always complete, regardless of `pause`.
- DRAIN: wait until the pipeline is empty (last `valid_out` emitted), then go to TAIL if FLUSH_TAIL_EN is defined, otherwise to DONE.
- TAIL:
  - hold `valid_out`=1 with `data_out_*`=0 for exactly WIDTH+1 cycles;
  - `pause` has no effect;
  - then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Counter width is ADDR_WIDTH. No wrap-around is allowed; the terminal compare is against WIDTH*HEIGHT-1.
- Reset mid-frame: next edge forces IDLE, clears the counter and pipeline, drops all outputs; no `done` is produced.

## Timing
- Reset values:
  - `mem_rd_en`, `mem_addr`, `data_out_*`, `valid_out`, `busy`, `done` are all 0;
  - state is IDLE.
- `start` sampled at edge E0 → `busy`=1 and first `mem_rd_en` after E0. First `valid_out`, with pixel 0, appears after E2: latency 2 cycles from the start edge.
- Without pause, `valid_out` is continuous for WIDTH*HEIGHT cycles.
- A `pause` pulse of N cycles produces an N-cycle hole in `valid_out`, lagging by 2 cycles; pixel order is unchanged.
- `pause` asserted in the same cycle that `start` is sampled: the FSM still enters STREAM, and the first read waits for `pause`=0.
- `done` asserts:
  - 1 cycle after the last valid beat when the tail is off;
  - 1 cycle after the last tail beat when the tail is on.
- `busy` falls together with `done`; a new `start` is accepted on the following cycle.

## Configuration
- Macro: `FMAP_SRC_FLUSH_TAIL_EN`.
- Defined: TAIL state present; WIDTH+1 zero-data valid beats follow the last pixel, so the line buffer flushes its final row.
- Undefined: TAIL is compiled out; DRAIN goes straight to DONE and `valid_out` drops immediately after pixel WIDTH*HEIGHT-1.

## Test plan
Common bench setup: WIDTH=4, HEIGHT=3, RAM model returning ch0=addr, ch1=addr+0x100, ch2=addr+0x200.
- Basic frame, tail off: pulse `start` → 12 consecutive `valid_out` beats with ch0 = 0…11 and ch1 = 0x100…0x10B, first beat 2 cycles after start. `done` pulses 1 cycle after beat 11.
- Tail on, same stimulus: 12 data beats, then 5 beats of `valid_out`=1 with all channels 0, then `done`; total `busy` time = 2+12+5+1 cycles.
- Pause: hold `pause` for 3 cycles after pixel 4 is issued → `valid_out` has exactly one 3-cycle gap after beat 4. The sequence is still 0…11, with no duplicates or drops.
- Start while busy: second `start` pulse at pixel 6 → ignored; exactly one `done` and 12 beats. A `start` the cycle after `done` launches a new frame from address 0.
- Reset mid-frame: assert `resetn` at pixel 7 for one cycle → all outputs 0 next cycle, no `done`. A following `start` restarts at address 0.
- Start with pause held: `start` and `pause` both high, release `pause` 4 cycles later → first `mem_rd_en` on release, first `valid_out` 2 cycles later.
